// File: rtl/exe_stage_pipe_if.sv
// -----------------------------------------------------------------------------
// exe_stage_pipe_if
//   Bundles the upstream operation bus, the downstream result bus and the
//   flush/busy sideband of the execute stage.
//
//   master : producer/consumer around the stage (drives operation, out_ready,
//            flush; observes results, handshakes and busy)
//   slave  : the execute stage itself
//
//   Upstream   : in_valid/in_ready, exe_cmd, pc, val1, rm, imm, shift_operand,
//                signed_imm, carry_in, is_mul, mem_r_en, mem_w_en, wb_en
//   Downstream : out_valid/out_ready, out_alu_res, out_rm, out_branch_addr,
//                out_status {N,Z,C,V}, out_mem_r, out_mem_w, out_wb
//   Sideband   : flush (in), busy (out, multiply in progress)
// -----------------------------------------------------------------------------
interface exe_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [IMM_W-1:0]  signed_imm;
  logic              carry_in;
  logic              is_mul;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              wb_en;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_res;
  logic [DATA_W-1:0] out_rm;
  logic [DATA_W-1:0] out_branch_addr;
  logic [3:0]        out_status;
  logic              out_mem_r;
  logic              out_mem_w;
  logic              out_wb;
  logic              busy;

  modport master (
    output in_valid, exe_cmd, pc, val1, rm, imm, shift_operand, signed_imm,
           carry_in, is_mul, mem_r_en, mem_w_en, wb_en, flush, out_ready,
    input  in_ready, out_valid, out_alu_res, out_rm, out_branch_addr,
           out_status, out_mem_r, out_mem_w, out_wb, busy
  );

  modport slave (
    input  in_valid, exe_cmd, pc, val1, rm, imm, shift_operand, signed_imm,
           carry_in, is_mul, mem_r_en, mem_w_en, wb_en, flush, out_ready,
    output in_ready, out_valid, out_alu_res, out_rm, out_branch_addr,
           out_status, out_mem_r, out_mem_w, out_wb, busy
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// -----------------------------------------------------------------------------
// exe_stage_pipe
//   Execute stage of an ARM-like pipeline with a one-deep output register.
//   Computes the second operand (immediate rotate / register shift / memory
//   offset), runs the ALU with ARM N,Z,C,V flags, forms the branch target and
//   optionally runs a shift-add multiplier that retires one multiplier bit per
//   cycle. Results are held until accepted downstream.
//
//   Ports
//     clk   : clock, all state updates on the rising edge
//     rest  : asynchronous active-low reset
//     bus   : exe_stage_pipe_if.slave (operation in, result out, flush, busy)
//
//   Parameters
//     DATA_W : datapath width (16..64)
//     IMM_W  : branch immediate width
//     MUL_EN : 1 builds the multiplier, 0 treats every operation as non-multiply
// -----------------------------------------------------------------------------
module exe_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24,
  parameter int MUL_EN = 1
) (
  input logic             clk,
  input logic             rest,
  exe_stage_pipe_if.slave bus
);

  localparam int MSB   = DATA_W - 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;

  // Rotate right within the datapath width; the amount wraps for narrow widths.
  function automatic logic [DATA_W-1:0] f_ror(input logic [DATA_W-1:0] x,
                                              input logic [4:0]        n);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} >> (int'(n) % DATA_W);
    return dbl[DATA_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_alu_res;
  logic [DATA_W-1:0] r_rm;
  logic [DATA_W-1:0] r_branch;
  logic [3:0]        r_status;
  logic              r_mem_r;
  logic              r_mem_w;
  logic              r_wb;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mul_cin;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [4:0]        w_sh_amt;
  logic [DATA_W-1:0] w_val2;
  logic [DATA_W-1:0] w_add_b;
  logic              w_add_cin;
  logic [DATA_W:0]   w_sum;
  logic              w_arith_v;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_c;
  logic              w_v;
  logic [DATA_W-1:0] w_branch;
  logic [DATA_W-1:0] w_mul_next;
  logic              w_is_mul;
  logic              w_take;

  assign w_sh_amt = bus.shift_operand[11:7];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin : val2_gen
    w_val2 = bus.rm;
    if (bus.mem_r_en || bus.mem_w_en) begin
      w_val2 = DATA_W'(bus.shift_operand);
    end else if (bus.imm) begin
      w_val2 = f_ror(DATA_W'(bus.shift_operand[7:0]), {bus.shift_operand[11:8], 1'b0});
    end else begin
      case (bus.shift_operand[6:5])
        2'b00:   w_val2 = bus.rm << w_sh_amt;
        2'b01:   w_val2 = bus.rm >> w_sh_amt;
        2'b10:   w_val2 = $signed(bus.rm) >>> w_sh_amt;
        default: w_val2 = f_ror(bus.rm, w_sh_amt);
      endcase
    end
  end

  // One adder serves all four arithmetic ops: subtraction adds ~val2 and the
  // carry-in supplies the +1 (SUB) or the ARM "not borrow" (SBC).
  always_comb begin : alu
    w_add_b   = ((bus.exe_cmd == OP_SUB) || (bus.exe_cmd == OP_SBC)) ? ~w_val2 : w_val2;
    w_add_cin = 1'b0;
    case (bus.exe_cmd)
      OP_ADC, OP_SBC: w_add_cin = bus.carry_in;
      OP_SUB:         w_add_cin = 1'b1;
      default:        w_add_cin = 1'b0;
    endcase
    w_sum     = {1'b0, bus.val1} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_add_cin};
    // Overflow: operands of equal sign producing a result of the other sign.
    w_arith_v = (bus.val1[MSB] == w_add_b[MSB]) && (w_sum[MSB] != bus.val1[MSB]);

    w_alu_res = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (bus.exe_cmd)
      OP_MOV: w_alu_res = w_val2;
      OP_MVN: w_alu_res = ~w_val2;
      OP_AND: w_alu_res = bus.val1 & w_val2;
      OP_ORR: w_alu_res = bus.val1 | w_val2;
      OP_EOR: w_alu_res = bus.val1 ^ w_val2;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_alu_res = w_sum[MSB:0];
        w_c       = w_sum[DATA_W];
        w_v       = w_arith_v;
      end
      default: w_alu_res = '0;
    endcase
  end

  assign w_branch   = bus.pc + DATA_W'($signed({bus.signed_imm, 2'b00}));
  assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_is_mul   = (MUL_EN != 0) && bus.is_mul;

  // Accept only in IDLE, or in HOLD while the held result leaves this cycle.
  assign bus.in_ready = rest && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_HOLD) && bus.out_ready));
  assign w_take       = bus.in_valid && bus.in_ready && !bus.flush;

  // ---------------------------------------------------------------------------
  // Sequential control and result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier
  // ones, which is how a new transfer supersedes the HOLD->IDLE drain.
  // NOTE: the result registers are reset as well as the control, because the
  // outputs must read zero while reset is asserted.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_alu_res <= '0;
      r_rm      <= '0;
      r_branch  <= '0;
      r_status  <= '0;
      r_mem_r   <= 1'b0;
      r_mem_w   <= 1'b0;
      r_wb      <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_mul_cin <= 1'b0;
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if ((r_state == ST_HOLD) && bus.out_ready) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end

      if (w_take) begin
        r_rm     <= bus.rm;
        r_branch <= w_branch;
        r_mem_r  <= bus.mem_r_en;
        r_mem_w  <= bus.mem_w_en;
        r_wb     <= bus.wb_en;
        if (w_is_mul) begin
          r_state   <= ST_MUL;
          r_valid   <= 1'b0;
          r_acc     <= '0;
          r_mcand   <= bus.val1;
          r_mplier  <= bus.rm;
          r_cnt     <= '0;
          r_mul_cin <= bus.carry_in;
        end else begin
          r_state   <= ST_HOLD;
          r_valid   <= 1'b1;
          r_alu_res <= w_alu_res;
          r_status  <= {w_alu_res[MSB], (w_alu_res == '0), w_c, w_v};
        end
      end

      // Shift-add: one multiplier bit per cycle, DATA_W cycles in total.
      if (r_state == ST_MUL) begin
        r_acc    <= w_mul_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          r_state   <= ST_HOLD;
          r_valid   <= 1'b1;
          r_alu_res <= w_mul_next;
          r_status  <= {w_mul_next[MSB], (w_mul_next == '0), r_mul_cin, 1'b0};
        end
      end
    end
  end

  assign bus.out_valid       = r_valid;
  assign bus.out_alu_res     = r_alu_res;
  assign bus.out_rm          = r_rm;
  assign bus.out_branch_addr = r_branch;
  assign bus.out_status      = r_status;
  assign bus.out_mem_r       = r_mem_r;
  assign bus.out_mem_w       = r_mem_w;
  assign bus.out_wb          = r_wb;
  assign bus.busy            = (r_state == ST_MUL);

endmodule
